// File: rtl/sap_pkg.sv
// Shared definitions for the SAP datapath distribution blocks.
package sap_pkg;

  localparam int SAP_WIDTH = 8;
  localparam int SAP_LINES = 16;
  localparam int SAP_SEL_W = 4;

  // Demux sequencer states: IDLE accepts requests, SWEEP replays one value to every line.
  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } demux_state_t;

  // Index to one-hot conversion, shared by the decoder and anything else that needs it.
  function automatic logic [SAP_LINES-1:0] to_onehot(input logic [SAP_SEL_W-1:0] idx);
    logic [SAP_LINES-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage : sap_pkg

// File: rtl/decoder_4to16.sv
// Combinational 4-bit index to 16-bit one-hot decoder with an enable.
// Drives both the per-line load enables and the registered strobe in the demux.
module decoder_4to16
  import sap_pkg::*;
(
  input  logic [SAP_SEL_W-1:0] idx,
  input  logic                 en,
  output logic [SAP_LINES-1:0] onehot
);

  // Decode the index when enabled, otherwise no line is selected.
  always_comb begin
    // NOTE: the default assignment before the branch keeps this purely combinational (no latch).
    onehot = '0;
    if (en) begin
      onehot = to_onehot(idx);
    end
  end

endmodule : decoder_4to16

// File: rtl/demux_16line_8bit.sv
// Registered 1-to-16 demultiplexer: delivers a bus value to one of sixteen
// holding registers, or sweeps one captured value across all sixteen lines.
module demux_16line_8bit
  import sap_pkg::*;
#(
  parameter int WIDTH = SAP_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in,
  input  logic [SAP_SEL_W-1:0] sel,
  input  logic                 wr_en,
  input  logic                 bcast,
  output logic [WIDTH-1:0]     out0,
  output logic [WIDTH-1:0]     out1,
  output logic [WIDTH-1:0]     out2,
  output logic [WIDTH-1:0]     out3,
  output logic [WIDTH-1:0]     out4,
  output logic [WIDTH-1:0]     out5,
  output logic [WIDTH-1:0]     out6,
  output logic [WIDTH-1:0]     out7,
  output logic [WIDTH-1:0]     out8,
  output logic [WIDTH-1:0]     out9,
  output logic [WIDTH-1:0]     out10,
  output logic [WIDTH-1:0]     out11,
  output logic [WIDTH-1:0]     out12,
  output logic [WIDTH-1:0]     out13,
  output logic [WIDTH-1:0]     out14,
  output logic [WIDTH-1:0]     out15,
  output logic [SAP_LINES-1:0] strobe,
  output logic                 busy
);

  localparam logic [SAP_SEL_W-1:0] LAST_LINE = SAP_SEL_W'(SAP_LINES - 1);

  demux_state_t         state;
  logic [SAP_SEL_W-1:0] cnt;
  logic [WIDTH-1:0]     data_q;
  logic [WIDTH-1:0]     line_q [SAP_LINES];

  logic                 sweeping;
  logic [SAP_SEL_W-1:0] dec_idx;
  logic                 dec_en;
  logic [WIDTH-1:0]     wr_data;
  logic [SAP_LINES-1:0] load_en;

  // Choose which line is written this cycle and with what value.
  // In IDLE a broadcast starts at line 0; during a sweep the counter owns the index
  // and the captured value is replayed, so bus changes cannot leak into the sweep.
  always_comb begin
    sweeping = (state == SWEEP);
    dec_idx  = sel;
    dec_en   = sweeping | wr_en;
    wr_data  = in;
    if (sweeping) begin
      dec_idx = cnt;
      wr_data = data_q;
    end else if (bcast) begin
      dec_idx = '0;
    end
  end

  decoder_4to16 u_decoder (
    .idx    (dec_idx),
    .en     (dec_en),
    .onehot (load_en)
  );

  // Sequencer: state, sweep counter, captured data, busy flag and load strobe.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      data_q <= '0;
      busy   <= 1'b0;
      strobe <= '0;
    end else begin
      strobe <= load_en;
      case (state)
        IDLE: begin
          if (wr_en && bcast) begin
            data_q <= in;
            cnt    <= SAP_SEL_W'(1);
            busy   <= 1'b1;
            state  <= SWEEP;
          end
        end
        SWEEP: begin
          // The edge that writes the last line also wraps the counter and ends the sweep.
          if (cnt == LAST_LINE) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + SAP_SEL_W'(1);
          end
        end
        default: begin
          cnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Holding registers: each line loads only when its enable is set, and all clear on reset.
  always_ff @(posedge clk) begin
    // NOTE: these sixteen registers are reset explicitly because a reset mid-sweep must clear lines already written.
    for (int i = 0; i < SAP_LINES; i++) begin
      if (rst) begin
        line_q[i] <= '0;
      end else if (load_en[i]) begin
        line_q[i] <= wr_data;
      end
    end
  end

  assign out0  = line_q[0];
  assign out1  = line_q[1];
  assign out2  = line_q[2];
  assign out3  = line_q[3];
  assign out4  = line_q[4];
  assign out5  = line_q[5];
  assign out6  = line_q[6];
  assign out7  = line_q[7];
  assign out8  = line_q[8];
  assign out9  = line_q[9];
  assign out10 = line_q[10];
  assign out11 = line_q[11];
  assign out12 = line_q[12];
  assign out13 = line_q[13];
  assign out14 = line_q[14];
  assign out15 = line_q[15];

endmodule : demux_16line_8bit

// File: tb/tb_demux_16line_8bit.sv
// Self-checking bench for demux_16line_8bit: directed scenarios with literal
// expectations plus a randomized run compared against a queue-based model.
module tb_demux_16line_8bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = '0;
  logic [3:0]  sel = '0;
  logic        wr_en = 1'b0;
  logic        bcast = 1'b0;
  logic [7:0]  dut_out [16];
  logic [15:0] dut_strobe;
  logic        dut_busy;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference model: line contents, last strobe, busy, and a queue of pending sweep writes.
  typedef struct {
    int         line;
    logic [7:0] val;
  } wr_t;

  logic [7:0]  m_out [16];
  logic [15:0] m_strobe;
  logic        m_busy;
  wr_t         pending [$];

  always #5 clk = ~clk;

  demux_16line_8bit #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .in     (din),
    .sel    (sel),
    .wr_en  (wr_en),
    .bcast  (bcast),
    .out0   (dut_out[0]),
    .out1   (dut_out[1]),
    .out2   (dut_out[2]),
    .out3   (dut_out[3]),
    .out4   (dut_out[4]),
    .out5   (dut_out[5]),
    .out6   (dut_out[6]),
    .out7   (dut_out[7]),
    .out8   (dut_out[8]),
    .out9   (dut_out[9]),
    .out10  (dut_out[10]),
    .out11  (dut_out[11]),
    .out12  (dut_out[12]),
    .out13  (dut_out[13]),
    .out14  (dut_out[14]),
    .out15  (dut_out[15]),
    .strobe (dut_strobe),
    .busy   (dut_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs the DUT samples there.
  task automatic model_step();
    wr_t e;
    if (rst) begin
      foreach (m_out[i]) m_out[i] = '0;
      m_strobe = '0;
      m_busy   = 1'b0;
      pending.delete();
    end else if (pending.size() > 0) begin
      e = pending.pop_front();
      m_out[e.line] = e.val;
      m_strobe      = 16'(32'(1) << e.line);
      m_busy        = (pending.size() > 0);
    end else if (wr_en && !bcast) begin
      m_out[sel] = din;
      m_strobe   = 16'(32'(1) << sel);
    end else if (wr_en && bcast) begin
      m_out[0] = din;
      m_strobe = 16'h0001;
      for (int k = 1; k < 16; k++) begin
        e.line = k;
        e.val  = din;
        pending.push_back(e);
      end
      m_busy = 1'b1;
    end else begin
      m_strobe = '0;
    end
  endtask

  // One clock cycle: apply inputs, let the edge happen, update the model, return at the falling edge.
  task automatic cyc(input logic r, input logic w, input logic b,
                     input logic [3:0] s, input logic [7:0] d);
    rst   = r;
    wr_en = w;
    bcast = b;
    sel   = s;
    din   = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("strobe", 32'(dut_strobe), 32'(m_strobe));
      check("busy", 32'(dut_busy), 32'(m_busy));
      for (int i = 0; i < 16; i++) begin
        check($sformatf("out%0d", i), 32'(dut_out[i]), 32'(m_out[i]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cycles;

    foreach (m_out[i]) m_out[i] = '0;
    m_strobe = '0;
    m_busy   = 1'b0;
    @(negedge clk);

    // Reset held two cycles with a write request pending.
    cyc(1'b1, 1'b1, 1'b0, 4'd5, 8'h77);
    cyc(1'b1, 1'b1, 1'b0, 4'd5, 8'h77);
    cmp_en = 1'b1;
    check("rst_strobe", 32'(dut_strobe), 32'h0);
    check("rst_busy", 32'(dut_busy), 32'h0);
    for (int i = 0; i < 16; i++) check($sformatf("rst_out%0d", i), 32'(dut_out[i]), 32'h0);

    // Single writes to every line.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 4'(i), 8'(i + 16));
      check("single_strobe", 32'(dut_strobe), 32'(1) << i);
      check("single_val", 32'(dut_out[i]), 32'(i + 16));
    end
    check("single_out15", 32'(dut_out[15]), 32'd31);
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    check("idle_strobe", 32'(dut_strobe), 32'h0);

    // Broadcast A5 with a single-write request to line 3 held throughout the sweep.
    busy_cycles = 0;
    cyc(1'b0, 1'b1, 1'b1, 4'd0, 8'hA5);
    check("bc_strobe0", 32'(dut_strobe), 32'h0001);
    check("bc_out0", 32'(dut_out[0]), 32'hA5);
    if (dut_busy) busy_cycles++;
    for (int k = 1; k < 16; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 4'd3, 8'h11);
      check($sformatf("bc_strobe%0d", k), 32'(dut_strobe), 32'(1) << k);
      if (dut_busy) busy_cycles++;
    end
    check("bc_busy_cycles", 32'(busy_cycles), 32'd15);
    check("bc_busy_end", 32'(dut_busy), 32'h0);
    check("ignored_out3", 32'(dut_out[3]), 32'hA5);
    for (int i = 0; i < 16; i++) check($sformatf("bc_line%0d", i), 32'(dut_out[i]), 32'hA5);
    // The held request is accepted at E16.
    cyc(1'b0, 1'b1, 1'b0, 4'd3, 8'h11);
    check("held_strobe", 32'(dut_strobe), 32'h0008);
    check("held_out3", 32'(dut_out[3]), 32'h11);

    // Reset at E5 of a sweep.
    cyc(1'b0, 1'b1, 1'b1, 4'd0, 8'h3C);
    for (int k = 1; k < 5; k++) cyc(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    check("pre_rst_out4", 32'(dut_out[4]), 32'h3C);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    check("mid_rst_busy", 32'(dut_busy), 32'h0);
    check("mid_rst_strobe", 32'(dut_strobe), 32'h0);
    for (int i = 0; i < 16; i++) check($sformatf("mid_rst_out%0d", i), 32'(dut_out[i]), 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 4'd7, 8'h42);
    check("post_rst_out7", 32'(dut_out[7]), 32'h42);
    check("post_rst_strobe", 32'(dut_strobe), 32'h0080);

    // Wrap boundary: line 15 holds FF until the sixteenth sweep edge writes 00.
    cyc(1'b0, 1'b1, 1'b0, 4'd15, 8'hFF);
    check("wrap_pre_out15", 32'(dut_out[15]), 32'hFF);
    cyc(1'b0, 1'b1, 1'b1, 4'd0, 8'h00);
    for (int k = 1; k < 15; k++) cyc(1'b0, 1'b0, 1'b0, 4'd0, 8'hEE);
    check("wrap_e14_out15", 32'(dut_out[15]), 32'hFF);
    check("wrap_e14_busy", 32'(dut_busy), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 8'hEE);
    check("wrap_e15_out15", 32'(dut_out[15]), 32'h00);
    check("wrap_e15_strobe", 32'(dut_strobe), 32'h8000);
    check("wrap_e15_busy", 32'(dut_busy), 32'h0);
    // A fresh broadcast must start at line 0 again.
    cyc(1'b0, 1'b1, 1'b1, 4'd9, 8'h77);
    check("restart_strobe", 32'(dut_strobe), 32'h0001);
    check("restart_out0", 32'(dut_out[0]), 32'h77);
    for (int k = 1; k < 16; k++) cyc(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    check("restart_done", 32'(dut_busy), 32'h0);

    // Randomized traffic, checked against the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
          8'($urandom_range(0, 255)));
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_demux_16line_8bit

// File: doc/demux_16line_8bit.md
# demux_16line_8bit

Registered 1-to-16 demultiplexer for the SAP datapath. It routes an 8-bit bus value to one of sixteen holding registers and pulses a one-hot load strobe for the selected line. A broadcast mode uses a counter-driven sequencer to write one captured value to all sixteen lines on consecutive cycles. It is the distribution counterpart of `mux_16line_8bit`: the mux selects a source onto the bus, and this block delivers a bus value to its destinations.

## Interface
- `WIDTH`, 8, data width of the input and of each output line.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in` input WIDTH: bus value to deliver.
- `sel` input 4: destination line index for a single write. Ignored in broadcast.
- `wr_en` input 1: write request, sampled on the rising edge. Ignored while `busy`=1.
- `bcast` input 1: qualifies `wr_en`. 1 selects a broadcast sweep; 0 selects a single write.
- `out0` … `out15` output WIDTH each: holding registers, one per line.
- `strobe` output 16: one-hot, one-cycle load pulse for the line written at the last edge. 0 when nothing was written.
- `busy` output 1: high while a broadcast sweep is in progress.

## Operation
- Reset, at any edge with `rst`=1:
  - all `outN` = 0, `strobe` = 0, `busy` = 0;
  - sweep counter = 0, captured data = 0, state = IDLE.
  - `rst` overrides every other input, including mid-sweep.
- There are two states, IDLE and SWEEP.
- IDLE, `wr_en`=1, `bcast`=0: `out[sel]` ← `in`. `strobe` = 1<<`sel` for the following cycle. Stay in IDLE. All other lines hold.
- IDLE, `wr_en`=1, `bcast`=1:
  - capture `in` into the data register;
  - `out0` ← `in`, `strobe` = 16'h0001;
  - counter ← 1, `busy` ← 1, go to SWEEP.
- IDLE, `wr_en`=0: no writes, `strobe` = 0.
- SWEEP: each edge does `out[cnt]` ← captured data, `strobe` = 1<<cnt, cnt ← cnt+1.
  - On the edge that writes line 15: `busy` ← 0, counter ← 0, go to IDLE.
  - `in`, `sel`, `wr_en` and `bcast` are ignored throughout SWEEP. Changing `in` mid-sweep does not alter the lines that remain to be written.
- Counter is 4 bits. Wrap-around from 15 to 0 coincides with the return to IDLE, and the counter never wraps while in SWEEP.
- Exactly one `strobe` bit is high on any cycle in which a write occurred. The outputs are zero-time registered: no combinational path from inputs to outputs.

## Timing
- Single write: accepted at edge E. The value is visible on `outN` and `strobe` after E. Latency is 1 cycle. Back-to-back single writes are accepted every cycle.
- Broadcast: accepted at edge E0, which writes line 0. Edges E1…E15 write lines 1…15.
  - `busy` is high from after E0 until after E15, i.e. 15 cycles.
  - `strobe` shows bit k during the cycle after Ek.
- A request is accepted only if `busy`=0 at the sampling edge. A request held during the final sweep cycle is ignored at E15. The first new acceptance is at E16.
- Reset mid-sweep: at the edge with `rst`=1, all outputs clear and the state returns to IDLE. Lines already written are cleared too.

## Structure
- Shared package `sap_pkg` holds:
  - `SAP_WIDTH`=8, `SAP_LINES`=16, `SAP_SEL_W`=4;
  - the `demux_state_t` enum {IDLE, SWEEP}.
- Sub-module `decoder_4to16` provides the combinational 4-bit index to 16-bit one-hot conversion. It is reused for both the `strobe` generation and the per-line load enables, with its index driven by `sel` in IDLE and by the counter in SWEEP.
- Top level contains the state register, counter, captured-data register and sixteen WIDTH-bit line registers.

## Test plan
- **Reset:** drive `rst`=1 for 2 cycles with `wr_en`=1. Required: all `outN`=0, `strobe`=0, `busy`=0.
- **Single writes:** for i=0..15, drive `sel`=i, `in`=8'd(i+16), `wr_en`=1 for one cycle. Required after each edge: `out[i]`=i+16, `strobe`=1<<i, all other lines unchanged. After the loop, `out15`=31.
- **Broadcast:** drive `in`=8'hA5, `bcast`=1, `wr_en`=1 for one cycle, then `in`=8'h00.
  - `strobe` walks 0x0001…0x8000 over 16 cycles.
  - `busy` is high for exactly 15 cycles.
  - All sixteen lines end at 8'hA5.
- **Ignored request:** during a sweep, drive `wr_en`=1, `bcast`=0, `sel`=3, `in`=8'h11. Required: `out3`=8'hA5, no extra strobe. A request held through E15 takes effect only at E16.
- **Reset mid-sweep:** assert `rst` at E5. Required: all lines=0, `busy`=0, `strobe`=0 after the edge. Next single write with `sel`=7, `in`=8'h42 gives `out7`=8'h42.
- **Zero/wrap boundary:** single write to `sel`=15 with `in`=8'hFF, then broadcast 8'h00. Required: `out15` becomes 0 on the sixteenth sweep edge, and the counter returns to 0 with IDLE.
